// File: rtl/motion_pkg.sv
// ============================================================================
// motion_pkg -- shared homing state encodings, parameter defaults and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package motion_pkg;

  localparam int DEF_STEP_PERIOD   = 2000;
  localparam int DEF_STEP_HIGH     = 1000;
  localparam int DEF_BACKOFF_STEPS = 16;
  localparam int DEF_TIMEOUT_STEPS = 20000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SEEK    = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_SETPOS  = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAULT   = 3'd6
  } hs_state_t;

  // Sub-phase of SEEK once the switch has been seen.
  typedef enum logic [1:0] {
    DET_NONE   = 2'd0,
    DET_FINISH = 2'd1,
    DET_WAIT   = 2'd2
  } det_phase_t;

  function automatic logic is_passthru(input hs_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_FAULT);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/step_pulse_gen.sv
// ============================================================================
// step_pulse_gen -- free-running step window: high for STEP_HIGH cycles at the
// start of every STEP_PERIOD window while enabled. Rev 1.0
// ============================================================================
`default_nettype none

module step_pulse_gen
  import motion_pkg::*;
#(
  parameter int STEP_PERIOD = DEF_STEP_PERIOD,
  parameter int STEP_HIGH   = DEF_STEP_HIGH
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_high,
  output logic o_done
);

  localparam int            CW     = $clog2(STEP_PERIOD);
  localparam logic [CW-1:0] c_LAST = CW'(STEP_PERIOD - 1);
  localparam logic [CW-1:0] c_HIGH = CW'(STEP_HIGH);

  logic [CW-1:0] r_cnt;

  // Dropping the enable restarts the next window from zero.
  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == c_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_high = i_en && (r_cnt < c_HIGH);
  assign o_done = i_en && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/homing_sequencer.sv
// ============================================================================
// homing_sequencer -- axis homing: clear alarms, seek switch, back off, load
// position. Optional SEEK step timeout with HOMING_TIMEOUT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module homing_sequencer
  import motion_pkg::*;
#(
  parameter int STEP_PERIOD   = DEF_STEP_PERIOD,
  parameter int STEP_HIGH     = DEF_STEP_HIGH,
  parameter int BACKOFF_STEPS = DEF_BACKOFF_STEPS,
  parameter int TIMEOUT_STEPS = DEF_TIMEOUT_STEPS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               homeDir,
  input  logic               homeSwitch,
  input  logic signed [15:0] homePosition,
  input  logic               engDir,
  input  logic               engStep,
  input  logic               limiterAlarm,
  output logic               axDir,
  output logic               axStep,
  output logic               setEnable,
  output logic signed [15:0] setPosition,
  output logic               alarmClear,
  output logic               busy,
  output logic               homed,
  output logic               fault
);

  if (STEP_PERIOD < 4 || STEP_HIGH < 1 || STEP_HIGH > STEP_PERIOD - 2 ||
      BACKOFF_STEPS < 1 || TIMEOUT_STEPS < 1) begin : g_param_check
    $error("homing_sequencer: parameter out of range");
  end

  localparam logic [15:0] c_BO_LAST = 16'(BACKOFF_STEPS - 1);

  hs_state_t          r_state, w_state_nx;
  det_phase_t         r_det, w_det_nx;
  logic [15:0]        r_bo_cnt, w_bo_cnt_nx;
  logic               r_sw_meta, r_sw_sync;
  logic               r_home_dir;
  logic               r_ax_dir, r_ax_step, r_set_en, r_alarm_clr;
  logic               r_busy, r_homed, r_fault;
  logic signed [15:0] r_set_pos;
  logic               w_gen_en, w_gen_high, w_gen_done;
  logic               w_seek_step, w_start_ok, w_timeout;
  logic               w_ax_dir_nx, w_ax_step_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_meta <= 1'b0;
      r_sw_sync <= 1'b0;
    end else begin
      r_sw_meta <= homeSwitch;
      r_sw_sync <= r_sw_meta;
    end
  end

  assign w_gen_en = (r_state == ST_CLEAR) || (r_state == ST_SEEK) ||
                    (r_state == ST_BACKOFF);

  step_pulse_gen #(
    .STEP_PERIOD (STEP_PERIOD),
    .STEP_HIGH   (STEP_HIGH)
  ) u_step_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_gen_en),
    .o_high (w_gen_high),
    .o_done (w_gen_done)
  );

  // A switch hit suppresses the step even in the cycle it is first seen.
  assign w_seek_step = (r_state == ST_SEEK) && (r_det == DET_NONE) &&
                       !r_sw_sync && w_gen_high;

`ifdef HOMING_TIMEOUT_EN
  localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_STEPS - 1);
  logic [15:0] r_seek_cnt;

  // A window that ends undetected has emitted exactly one step.
  always_ff @(posedge clk) begin
    if (rst || r_state != ST_SEEK) begin
      r_seek_cnt <= '0;
    end else if (w_gen_done && r_det == DET_NONE && !r_sw_sync) begin
      r_seek_cnt <= sat_inc16(r_seek_cnt);
    end
  end

  assign w_timeout = (r_seek_cnt >= c_TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nx  = r_state;
    w_det_nx    = r_det;
    w_bo_cnt_nx = r_bo_cnt;
    w_start_ok  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (start) begin
          w_state_nx = ST_CLEAR;
          w_start_ok = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (w_gen_done) w_state_nx = ST_SEEK;
      end
      ST_SEEK: begin
        case (r_det)
          DET_NONE: begin
            if (r_sw_sync)                    w_det_nx = w_gen_done ? DET_WAIT : DET_FINISH;
            else if (w_gen_done && w_timeout) w_state_nx = ST_FAULT;
          end
          DET_FINISH: if (w_gen_done) w_det_nx = DET_WAIT;
          DET_WAIT:   if (w_gen_done) w_state_nx = ST_BACKOFF;
          default:    w_det_nx = DET_NONE;
        endcase
        if (limiterAlarm) w_state_nx = ST_FAULT;
      end
      ST_BACKOFF: begin
        if (w_gen_done) begin
          w_bo_cnt_nx = sat_inc16(r_bo_cnt);
          if (r_bo_cnt >= c_BO_LAST) w_state_nx = r_sw_sync ? ST_FAULT : ST_SETPOS;
        end
        if (limiterAlarm) w_state_nx = ST_FAULT;
      end
      ST_SETPOS: w_state_nx = ST_DONE;
      default:   w_state_nx = ST_IDLE;
    endcase
    if (w_state_nx != ST_SEEK)    w_det_nx    = DET_NONE;
    if (w_state_nx != ST_BACKOFF) w_bo_cnt_nx = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_det    <= DET_NONE;
      r_bo_cnt <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_det    <= w_det_nx;
      r_bo_cnt <= w_bo_cnt_nx;
    end
  end

  // Axis outputs are registered; passthrough applies as soon as the sequence ends.
  always_comb begin
    w_ax_dir_nx  = r_home_dir;
    w_ax_step_nx = 1'b0;
    if (is_passthru(w_state_nx)) begin
      w_ax_dir_nx  = engDir;
      w_ax_step_nx = engStep;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_FAULT: w_ax_dir_nx = homeDir;
        ST_SEEK: begin
          w_ax_dir_nx  = (r_det != DET_NONE || r_sw_sync) ? ~r_home_dir : r_home_dir;
          w_ax_step_nx = w_seek_step;
        end
        ST_BACKOFF: begin
          w_ax_dir_nx  = ~r_home_dir;
          w_ax_step_nx = w_gen_high;
        end
        ST_SETPOS: w_ax_dir_nx = ~r_home_dir;
        default:   w_ax_dir_nx = r_home_dir;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ax_dir    <= 1'b0;
      r_ax_step   <= 1'b0;
      r_set_en    <= 1'b0;
      r_alarm_clr <= 1'b0;
      r_busy      <= 1'b0;
      r_homed     <= 1'b0;
      r_fault     <= 1'b0;
      r_set_pos   <= '0;
      r_home_dir  <= 1'b0;
    end else begin
      r_ax_dir    <= w_ax_dir_nx;
      r_ax_step   <= w_ax_step_nx;
      r_set_en    <= (w_state_nx == ST_SETPOS);
      r_alarm_clr <= w_start_ok;
      r_busy      <= !is_passthru(w_state_nx);
      r_homed     <= (w_state_nx == ST_DONE);
      r_fault     <= (w_state_nx == ST_FAULT);
      if (w_start_ok) begin
        r_set_pos  <= homePosition;
        r_home_dir <= homeDir;
      end
    end
  end

  assign axDir       = r_ax_dir;
  assign axStep      = r_ax_step;
  assign setEnable   = r_set_en;
  assign setPosition = r_set_pos;
  assign alarmClear  = r_alarm_clr;
  assign busy        = r_busy;
  assign homed       = r_homed;
  assign fault       = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_homing_sequencer.sv
// ============================================================================
// tb_homing_sequencer -- table-driven homing scenarios with an expectation
// queue, plus alarm, reset-abort and passthrough sequences. Rev 1.0
// ============================================================================
`default_nettype none

module tb_homing_sequencer;

  localparam int P  = 8;
  localparam int H  = 4;
  localparam int BO = 4;
  localparam int TO = 10;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, homeDir = 1'b1, homeSwitch = 1'b0;
  logic engDir = 1'b0, engStep = 1'b0, limiterAlarm = 1'b0;
  logic signed [15:0] homePosition = 16'sd0;
  logic axDir, axStep, setEnable, alarmClear, busy, homed, fault;
  logic signed [15:0] setPosition;

  homing_sequencer #(
    .STEP_PERIOD   (P),
    .STEP_HIGH     (H),
    .BACKOFF_STEPS (BO),
    .TIMEOUT_STEPS (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .homeDir      (homeDir),
    .homeSwitch   (homeSwitch),
    .homePosition (homePosition),
    .engDir       (engDir),
    .engStep      (engStep),
    .limiterAlarm (limiterAlarm),
    .axDir        (axDir),
    .axStep       (axStep),
    .setEnable    (setEnable),
    .setPosition  (setPosition),
    .alarmClear   (alarmClear),
    .busy         (busy),
    .homed        (homed),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Free-running event counters; scenarios work on differences.
  int pos_cnt = 0, neg_cnt = 0, set_cnt = 0, clr_cnt = 0;
  logic signed [15:0] set_val = 16'sd0;
  logic prev_step = 1'b0;

  always @(negedge clk) begin
    if (axStep && !prev_step) begin
      if (axDir) pos_cnt++;
      else       neg_cnt++;
    end
    prev_step = axStep;
    if (setEnable) begin
      set_cnt++;
      set_val = setPosition;
    end
    if (alarmClear) clr_cnt++;
  end

  // mode: 0 = raise switch after raise_after steps, 1 = high before start, 2 = never
  typedef struct {
    logic               dir;
    int                 mode;
    int                 raise_after;
    logic               restart;
    logic signed [15:0] pos;
    int                 exp_fwd;
    int                 exp_bwd;
    int                 exp_set;
    int                 exp_homed;
    int                 exp_fault;
  } vec_t;

  vec_t       vecs[$];
  vec_t       sb[$];
  logic [1:0] ptq[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int p0, n0, s0, c0, fwd, bwd, cyc;
    bit raised, lowered, restarted;
    vec_t e;
    raised = 0; lowered = 0; restarted = 0;
    homeDir      = v.dir;
    homePosition = v.pos;
    homeSwitch   = (v.mode == 1);
    repeat (4) tick();
    p0 = pos_cnt; n0 = neg_cnt; s0 = set_cnt; c0 = clr_cnt;
    sb.push_back(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    cyc = 0;
    while (busy && cyc < 5000) begin
      fwd = v.dir ? pos_cnt - p0 : neg_cnt - n0;
      bwd = v.dir ? neg_cnt - n0 : pos_cnt - p0;
      if (v.mode == 0 && !raised && fwd >= v.raise_after && !axStep) begin
        homeSwitch = 1'b1;
        raised = 1;
      end
      if (v.mode == 0 && raised && !lowered && bwd >= 2 && !axStep) begin
        homeSwitch = 1'b0;
        lowered = 1;
      end
      if (v.restart && !restarted && fwd >= 2) begin
        start = 1'b1;
        restarted = 1;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check("seq_within_budget", int'(cyc < 5000), 1);
    e   = sb.pop_front();
    fwd = e.dir ? pos_cnt - p0 : neg_cnt - n0;
    bwd = e.dir ? neg_cnt - n0 : pos_cnt - p0;
    check("seek_steps", fwd, e.exp_fwd);
    check("backoff_steps", bwd, e.exp_bwd);
    check("setEnable_cycles", set_cnt - s0, e.exp_set);
    check("alarmClear_pulses", clr_cnt - c0, 1);
    check("homed", int'(homed), e.exp_homed);
    check("fault", int'(fault), e.exp_fault);
    check("setPosition_held", int'(setPosition), int'(e.pos));
    if (e.exp_set != 0) check("setPosition_at_setEnable", int'(set_val), int'(e.pos));
    check("axStep_idle_low", int'(axStep), 0);
    homeSwitch = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, n0, cyc;
    bit raised;
    logic prev;
    logic [1:0] exp2;

    vecs.push_back('{dir:1'b1, mode:1, raise_after:0, restart:1'b0, pos:16'sd77,
                     exp_fwd:0, exp_bwd:BO, exp_set:0, exp_homed:0, exp_fault:1});
`ifdef HOMING_TIMEOUT_EN
    vecs.push_back('{dir:1'b1, mode:2, raise_after:0, restart:1'b0, pos:16'sd5,
                     exp_fwd:TO, exp_bwd:0, exp_set:0, exp_homed:0, exp_fault:1});
`endif
    vecs.push_back('{dir:1'b1, mode:0, raise_after:5, restart:1'b0, pos:16'sh0123,
                     exp_fwd:5, exp_bwd:BO, exp_set:1, exp_homed:1, exp_fault:0});
    vecs.push_back('{dir:1'b0, mode:0, raise_after:3, restart:1'b1, pos:-16'sd1234,
                     exp_fwd:3, exp_bwd:BO, exp_set:1, exp_homed:1, exp_fault:0});
    vecs.push_back('{dir:1'b1, mode:0, raise_after:1, restart:1'b0, pos:16'sh7FF0,
                     exp_fwd:1, exp_bwd:BO, exp_set:1, exp_homed:1, exp_fault:0});

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_axStep", int'(axStep), 0);
    check("rst_axDir", int'(axDir), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_homed", int'(homed), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_setEnable", int'(setEnable), 0);
    check("rst_alarmClear", int'(alarmClear), 0);
    check("rst_setPosition", int'(setPosition), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Limiter alarm during the 3rd SEEK step
    homeDir = 1'b1;
    homePosition = 16'sd9;
    p0 = pos_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!((pos_cnt - p0) >= 3 && axStep) && cyc < 500) begin
      tick();
      cyc++;
    end
    check("alarm_reach_step3", int'(cyc < 500), 1);
    limiterAlarm = 1'b1;
    tick();
    limiterAlarm = 1'b0;
    check("alarm_fault", int'(fault), 1);
    check("alarm_busy", int'(busy), 0);
    check("alarm_axStep_low", int'(axStep), 0);
    check("alarm_seek_steps", pos_cnt - p0, 3);
    engStep = 1'b1;
    tick();
    check("alarm_passthru_high", int'(axStep), 1);
    engStep = 1'b0;
    tick();
    check("alarm_passthru_low", int'(axStep), 0);
    repeat (2) tick();

    // Reset while a BACKOFF step is high
    homeDir = 1'b1;
    homePosition = 16'sh7ABC;
    n0 = neg_cnt;
    p0 = pos_cnt;
    raised = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(busy && axStep && !axDir) && cyc < 2000) begin
      if (!raised && (pos_cnt - p0) >= 2 && !axStep) begin
        homeSwitch = 1'b1;
        raised = 1;
      end
      tick();
      cyc++;
    end
    check("rst_mid_backoff_reached", int'(cyc < 2000), 1);
    rst = 1'b1;
    tick();
    check("abort_axStep", int'(axStep), 0);
    check("abort_axDir", int'(axDir), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_homed", int'(homed), 0);
    check("abort_fault", int'(fault), 0);
    check("abort_setEnable", int'(setEnable), 0);
    check("abort_alarmClear", int'(alarmClear), 0);
    check("abort_setPosition", int'(setPosition), 0);
    rst = 1'b0;
    homeSwitch = 1'b0;
    repeat (4) tick();

    // Table-driven homing scenarios
    foreach (vecs[i]) run_vec(vecs[i]);

    // Passthrough in DONE: engStep toggled with engDir=0, one cycle of latency
    check("pt_in_done", int'(homed), 1);
    engDir = 1'b0;
    for (int i = 0; i < 6; i++) begin
      prev    = axStep;
      engStep = (i % 2 == 0);
      ptq.push_back({engDir, engStep});
      #1;
      check("pt_not_combinational", int'(axStep), int'(prev));
      tick();
      exp2 = ptq.pop_front();
      check("pt_axDir", int'(axDir), int'(exp2[1]));
      check("pt_axStep", int'(axStep), int'(exp2[0]));
    end
    check("pt_busy", int'(busy), 0);
    engStep = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
